// File: rtl/display_registrador7b_pkg.sv
// Shared types and constants for the 7-bit register display path.
// Holds the conversion FSM states, sizing constants, active-low segment patterns
// and the per-nibble double-dabble correction step.
package display_registrador7b_pkg;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    CONVERTE = 2'd1,
    CARREGA  = 2'd2
  } estado_t;

  localparam int N_DIGITOS = 3;
  localparam int N_BITS    = 7;
  localparam int ITERACOES = 7;
  // BCD digits sit above the binary input in one shift register.
  localparam int SHIFT_W   = 4 * N_DIGITOS + N_BITS;

  // Segment order {g,f,e,d,c,b,a}, active-low.
  localparam logic [6:0] SEG_0       = 7'b1000000;
  localparam logic [6:0] SEG_1       = 7'b1111001;
  localparam logic [6:0] SEG_2       = 7'b0100100;
  localparam logic [6:0] SEG_3       = 7'b0110000;
  localparam logic [6:0] SEG_4       = 7'b0011001;
  localparam logic [6:0] SEG_5       = 7'b0010010;
  localparam logic [6:0] SEG_6       = 7'b0000010;
  localparam logic [6:0] SEG_7       = 7'b1111000;
  localparam logic [6:0] SEG_8       = 7'b0000000;
  localparam logic [6:0] SEG_9       = 7'b0010000;
  localparam logic [6:0] SEG_APAGADO = 7'b1111111;

  // A nibble of 5 or more would overflow past 9 when doubled, so it is
  // pre-corrected by 3 before the shift.
  function automatic logic [3:0] ajusta_bcd(input logic [3:0] n);
    return (n >= 4'd5) ? (n + 4'd3) : n;
  endfunction

endpackage

// File: rtl/display_registrador7b_decodificador_7seg.sv
// BCD digit to active-low 7-segment decoder with blanking input.
// Latency: combinational. Backpressure: none.
// Ports: bcd (4-bit digit), apagar (1 = blank), segmentos ({g,f,e,d,c,b,a}, active-low).
module decodificador_7seg
  import display_registrador7b_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       apagar,
  output logic [6:0] segmentos
);

  always_comb begin
    segmentos = SEG_APAGADO;
    if (!apagar) begin
      unique case (bcd)
        4'd0:    segmentos = SEG_0;
        4'd1:    segmentos = SEG_1;
        4'd2:    segmentos = SEG_2;
        4'd3:    segmentos = SEG_3;
        4'd4:    segmentos = SEG_4;
        4'd5:    segmentos = SEG_5;
        4'd6:    segmentos = SEG_6;
        4'd7:    segmentos = SEG_7;
        4'd8:    segmentos = SEG_8;
        4'd9:    segmentos = SEG_9;
        default: segmentos = SEG_APAGADO;
      endcase
    end
  end

endmodule

// File: rtl/display_registrador7b.sv
// Register value -> 3-digit BCD (double-dabble) -> multiplexed active-low 7-seg display.
// Latency: 8 cycles from accepted request to new digits (pronto the cycle after).
// Backpressure: requests while busy collapse into one pending conversion, run at the next idle edge.
// Ports: clk, reset (async, active-high), valores_registrador[6:0], atualizar,
//        segmentos[6:0] {g..a} active-low, digitos[2:0] active-low one-hot, ocupado, pronto.
module display_registrador7b
  import display_registrador7b_pkg::*;
#(
  parameter int PRESCALE = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] valores_registrador,
  input  logic       atualizar,
  output logic [6:0] segmentos,
  output logic [2:0] digitos,
  output logic       ocupado,
  output logic       pronto
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  estado_t              estado_q, estado_d;
  logic                 pendente_q, pendente_d;
  logic [2:0]           iter_q, iter_d;
  logic [SHIFT_W-1:0]   shift_q, shift_d;
  logic [SHIFT_W-1:0]   ajustado;
  logic [3:0]           uni_q, uni_d;
  logic [3:0]           dez_q, dez_d;
  logic [3:0]           cen_q, cen_d;
  logic                 pronto_q, pronto_d;
  logic [PW-1:0]        presc_q, presc_d;
  logic [1:0]           idx_q, idx_d;

  logic [3:0]           nibble_sel;
  logic                 apagar_sel;

  // Correct every BCD nibble first; the binary part below is untouched.
  always_comb begin
    ajustado = {ajusta_bcd(shift_q[18:15]),
                ajusta_bcd(shift_q[14:11]),
                ajusta_bcd(shift_q[10:7]),
                shift_q[6:0]};
  end

  always_comb begin
    estado_d   = estado_q;
    pendente_d = pendente_q;
    iter_d     = iter_q;
    shift_d    = shift_q;
    uni_d      = uni_q;
    dez_d      = dez_q;
    cen_d      = cen_q;
    pronto_d   = 1'b0;

    unique case (estado_q)
      OCIOSO: begin
        // Input is sampled here, so a pending request sees the latest value.
        if (atualizar || pendente_q) begin
          shift_d    = {{(4 * N_DIGITOS){1'b0}}, valores_registrador};
          iter_d     = 3'd0;
          pendente_d = 1'b0;
          estado_d   = CONVERTE;
        end
      end
      CONVERTE: begin
        if (atualizar) pendente_d = 1'b1;
        shift_d = ajustado << 1;
        iter_d  = iter_q + 3'd1;
        if (iter_q == 3'(ITERACOES - 1)) estado_d = CARREGA;
      end
      CARREGA: begin
        if (atualizar) pendente_d = 1'b1;
        cen_d    = shift_q[18:15];
        dez_d    = shift_q[14:11];
        uni_d    = shift_q[10:7];
        pronto_d = 1'b1;
        estado_d = OCIOSO;
      end
      default: estado_d = OCIOSO;
    endcase
  end

  // Scan timing is free-running and independent of the conversion FSM.
  always_comb begin
    presc_d = presc_q;
    idx_d   = idx_q;
    if (presc_q == PW'(PRESCALE - 1)) begin
      presc_d = '0;
      idx_d   = (idx_q == 2'd2) ? 2'd0 : (idx_q + 2'd1);
    end else begin
      presc_d = presc_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q   <= OCIOSO;
      pendente_q <= 1'b0;
      iter_q     <= 3'd0;
      shift_q    <= '0;
      uni_q      <= 4'd0;
      dez_q      <= 4'd0;
      cen_q      <= 4'd0;
      pronto_q   <= 1'b0;
      presc_q    <= '0;
      idx_q      <= 2'd0;
    end else begin
      estado_q   <= estado_d;
      pendente_q <= pendente_d;
      iter_q     <= iter_d;
      shift_q    <= shift_d;
      uni_q      <= uni_d;
      dez_q      <= dez_d;
      cen_q      <= cen_d;
      pronto_q   <= pronto_d;
      presc_q    <= presc_d;
      idx_q      <= idx_d;
    end
  end

  // Leading-zero blanking: an interior zero (e.g. the tens of 100) stays lit.
  always_comb begin
    nibble_sel = uni_q;
    apagar_sel = 1'b0;
    digitos    = 3'b111;
    unique case (idx_q)
      2'd0: begin
        nibble_sel = uni_q;
        apagar_sel = 1'b0;
        digitos    = 3'b110;
      end
      2'd1: begin
        nibble_sel = dez_q;
        apagar_sel = (cen_q == 4'd0) && (dez_q == 4'd0);
        digitos    = 3'b101;
      end
      2'd2: begin
        nibble_sel = cen_q;
        apagar_sel = (cen_q == 4'd0);
        digitos    = 3'b011;
      end
      default: begin
        nibble_sel = uni_q;
        apagar_sel = 1'b1;
        digitos    = 3'b111;
      end
    endcase
  end

  decodificador_7seg u_decod (
    .bcd       (nibble_sel),
    .apagar    (apagar_sel),
    .segmentos (segmentos)
  );

  assign ocupado = (estado_q != OCIOSO);
  assign pronto  = pronto_q;

endmodule

// File: tb/tb_display_registrador7b.sv
module tb_display_registrador7b;

  logic       clk;
  logic       reset;
  logic [6:0] valores_registrador;
  logic       atualizar;
  logic [6:0] segmentos;
  logic [2:0] digitos;
  logic       ocupado;
  logic       pronto;

  int checks   = 0;
  int failures = 0;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SB = 7'b1111111;

  display_registrador7b #(.PRESCALE(1)) dut (
    .clk                 (clk),
    .reset               (reset),
    .valores_registrador (valores_registrador),
    .atualizar           (atualizar),
    .segmentos           (segmentos),
    .digitos             (digitos),
    .ocupado             (ocupado),
    .pronto              (pronto)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One-cycle request; returns at the negedge following the sampling edge E0.
  task automatic pulse_req(input logic [6:0] v);
    @(negedge clk);
    valores_registrador = v;
    atualizar = 1'b1;
    @(negedge clk);
    atualizar = 1'b0;
  endtask

  // Negedges until pronto seen (8 expected after pulse_req); 0 = timed out.
  task automatic wait_pronto(output int n);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (pronto) begin
        n = i;
        break;
      end
    end
  endtask

  // PRESCALE=1 so three consecutive cycles cover all digits.
  task automatic check_scan(input string tag, input logic [6:0] u, input logic [6:0] t,
                            input logic [6:0] h);
    logic [2:0] seen;
    seen = 3'b000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      case (digitos)
        3'b110:  begin check({tag, "_uni"}, segmentos, u); seen[0] = 1'b1; end
        3'b101:  begin check({tag, "_dez"}, segmentos, t); seen[1] = 1'b1; end
        3'b011:  begin check({tag, "_cen"}, segmentos, h); seen[2] = 1'b1; end
        default: check({tag, "_digitos"}, digitos, 3'b110);
      endcase
    end
    check({tag, "_cover"}, seen, 3'b111);
  endtask

  initial begin
    int n;
    int np;
    int first_at;
    int second_at;

    reset = 1'b1;
    valores_registrador = 7'd0;
    atualizar = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_digitos", digitos, 3'b110);
    check("rst_seg", segmentos, S0);
    check("rst_ocupado", ocupado, 1'b0);
    check("rst_pronto", pronto, 1'b0);
    reset = 1'b0;
    @(negedge clk); check("scan1_dig", digitos, 3'b101); check("scan1_seg", segmentos, SB);
    @(negedge clk); check("scan2_dig", digitos, 3'b011); check("scan2_seg", segmentos, SB);
    @(negedge clk); check("scan3_dig", digitos, 3'b110); check("scan3_seg", segmentos, S0);

    // 127: busy for 8 cycles, pronto right after.
    pulse_req(7'd127);
    for (int i = 0; i < 8; i++) begin
      check("busy127_ocupado", ocupado, 1'b1);
      check("busy127_pronto", pronto, 1'b0);
      @(negedge clk);
    end
    check("done127_ocupado", ocupado, 1'b0);
    check("done127_pronto", pronto, 1'b1);
    @(negedge clk);
    check("after127_pronto", pronto, 1'b0);
    check_scan("v127", S7, S2, S1);

    pulse_req(7'd5);
    wait_pronto(n);
    check("lat5", n, 8);
    check_scan("v5", S5, SB, SB);

    pulse_req(7'd100);
    wait_pronto(n);
    check("lat100", n, 8);
    check_scan("v100", S0, S0, S1);

    // Repeated requests during conversion of 42 collapse into one, which samples 9.
    pulse_req(7'd42);
    @(negedge clk);
    atualizar = 1'b1;
    repeat (3) @(negedge clk);
    atualizar = 1'b0;
    valores_registrador = 7'd9;
    np = 0; first_at = 0; second_at = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (pronto) begin
        np++;
        if (np == 1) first_at = i;
        if (np == 2) second_at = i;
      end
    end
    check("pend_count", np, 2);
    check("pend_period", second_at - first_at, 9);
    check_scan("v9", S9, SB, SB);

    // Reset during iteration 4 of 127 aborts the conversion and restores "0".
    pulse_req(7'd127);
    repeat (3) @(negedge clk);
    check("mid_ocupado", ocupado, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_ocupado", ocupado, 1'b0);
    check("abort_pronto", pronto, 1'b0);
    check("abort_digitos", digitos, 3'b110);
    check("abort_seg", segmentos, S0);
    reset = 1'b0;
    np = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (pronto) np++;
    end
    check("abort_no_pronto", np, 0);
    check_scan("v0", S0, SB, SB);

    pulse_req(7'd64);
    wait_pronto(n);
    check("lat64", n, 8);
    check_scan("v64", S4, S6, SB);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/display_registrador7b.md
# display_registrador7b

Downstream consumer of the 7-bit register bank: it captures the 7-bit unsigned value held in the register and converts it to three BCD digits with a sequential shift-add-3 (double-dabble) engine. It then drives a multiplexed, active-low 3-digit 7-segment display. Conversion runs only on request, so the display holds steady between register writes.

## Interface

Parameters:
- PRESCALE, 50000, clk cycles per digit-scan step (≥1; 1 = advance every cycle, used in simulation)

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- valores_registrador  in  7  unsigned register contents, 0–127
- atualizar  in  1  conversion request, sampled each rising edge
- segmentos  out  7  {g,f,e,d,c,b,a}, active-low
- digitos  out  3  one-hot digit enable, active-low; bit0 units, bit1 tens, bit2 hundreds
- ocupado  out  1  high while a conversion is in flight
- pronto  out  1  one-cycle pulse when new digits reach the display

## Operation

- FSM states: OCIOSO, CONVERTE, CARREGA.
- OCIOSO: on atualizar=1 or pendente=1:
  - load the shift register with {12'b0, valores_registrador}
  - clear the iteration counter and pendente
  - go to CONVERTE
- CONVERTE: each cycle, add 3 to every BCD nibble ≥5, then shift left by 1.
  - 7 iterations (counter 0..6); after the 7th, go to CARREGA.
- CARREGA: copy the three BCD nibbles into the display registers, pulse pronto, return to OCIOSO.
- atualizar=1 while not in OCIOSO sets pendente. Multiple requests collapse into one.
  - The pending conversion samples valores_registrador on the first OCIOSO edge, not at request time.
- Scan:
  - The prescaler counts 0..PRESCALE-1. At terminal count it wraps to 0 and the digit index advances 0→1→2→0.
  - The scan runs independently of the FSM.
- Segment patterns (active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Nibble values 10–15 cannot occur; the decoder outputs 1111111 for them.
- Leading-zero blanking:
  - Hundreds are blanked when 0.
  - Tens are blanked when both hundreds and tens are 0.
  - Units are never blanked.
  - Blanked digit: enable still asserted, segmentos = 1111111.

## Timing

- Reset values:
  - state OCIOSO; pendente 0; ocupado 0; pronto 0
  - display nibbles 0/0/0; digit index 0; prescaler 0
  - digitos = 110, segmentos = 1000000 (display shows "0")
- Request at edge E0 in OCIOSO gives:
  - ocupado=1 from E0 through E8; conversion iterations on E1..E7
  - CARREGA executes on E8: display registers updated, pronto=1 for the cycle after E8, ocupado=0 after E8
  - Request-to-display latency is 8 cycles.
- pendente:
  - A pending request captured at E8 starts the next conversion at E9.
  - Back-to-back conversions therefore have a 9-cycle period.
- Display nibbles change only on a CARREGA edge; no partial digits are ever visible.
- Scan: digitos and segmentos change together on the prescaler-wrap edge. Each digit is shown for PRESCALE cycles.
- Reset asserted mid-conversion aborts immediately:
  - outputs return to reset values
  - the in-flight conversion and pendente are discarded
  - no pronto is issued

## Structure

- Shared package:
  - state enum (OCIOSO, CONVERTE, CARREGA)
  - N_DIGITOS = 3, N_BITS = 7, ITERACOES = 7
  - the ten segment constants and SEG_APAGADO = 7'b1111111
- Sub-module decodificador_7seg: combinational 4-bit BCD plus blank input → 7-bit active-low segments. Reused by later display blocks.
- The double-dabble engine, FSM, prescaler and scan mux live in the top module.

## Test plan

- Reset with PRESCALE=1: digitos cycles 110→101→011; segmentos = 1000000, 1111111, 1111111; ocupado=0, pronto=0.
- valores_registrador=127, atualizar pulse:
  - ocupado for 8 cycles; pronto one cycle later
  - scan shows units 1111000 (7), tens 0100100 (2), hundreds 1111001 (1)
- Value 5: units 0010010, tens and hundreds 1111111.
- Value 100: units 1000000, tens 1000000 (interior zero not blanked), hundreds 1111001.
- atualizar=1 for three cycles during conversion of 42, input then changed to 9:
  - exactly two pronto pulses, 9 cycles apart
  - final display is "9"
- Reset asserted at iteration 4 of converting 127:
  - display returns to "0", no pronto
  - a fresh request for 64 yields "64" after 8 cycles
